// File: rtl/pwm_capture_if.sv
// pwm_capture_if: PWM line and measurement results of the pwm_capture block.
//   pwm_in        asynchronous PWM line being measured
//   duty          high time of the last complete period, in clk cycles (W bits)
//   period        length of the last complete period, in clk cycles (W bits)
//   sample_valid  one-cycle pulse when duty/period update
//   stuck_high    level: line held high for the timeout
//   stuck_low     level: line held low for the timeout
//   locked        level: at least one valid sample since idle/stuck
// master: owner of the PWM line and consumer of results; slave: pwm_capture.
interface pwm_capture_if #(
  parameter int unsigned W = 12
);
  logic         pwm_in;
  logic [W-1:0] duty;
  logic [W-1:0] period;
  logic         sample_valid;
  logic         stuck_high;
  logic         stuck_low;
  logic         locked;

  modport master (
    output pwm_in,
    input  duty, period, sample_valid, stuck_high, stuck_low, locked
  );

  modport slave (
    input  pwm_in,
    output duty, period, sample_valid, stuck_high, stuck_low, locked
  );
endinterface

// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and period of an external PWM waveform in
// clk cycles and flags a line stuck high or stuck low.
// Ports:
//   clk   single clock, all state on posedge
//   rst   asynchronous active-high reset
//   bus   pwm_capture_if.slave: pwm_in in; duty, period, sample_valid,
//         stuck_high, stuck_low, locked out (all registered)
// Optional glitch filter: define PWM_CAPTURE_FILTER_EN. The synchronized line
// then has to hold a new value for FILTER_DEPTH cycles before it is believed.
module pwm_capture #(
  parameter int unsigned PWM_INTERVAL   = 1800,
  parameter int unsigned TIMEOUT_CYCLES = 2 * PWM_INTERVAL,
  parameter int unsigned FILTER_DEPTH   = 3
) (
  input  logic         clk,
  input  logic         rst,
  pwm_capture_if.slave bus
);
  localparam int unsigned W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [W-1:0] CNT_ONE  = W'(1);
  localparam logic [W-1:0] CNT_LAST = W'(TIMEOUT_CYCLES - 1);
  localparam logic [W-1:0] CNT_MAX  = W'(TIMEOUT_CYCLES);

  // Reject parameter sets that would make the counters or filter meaningless
  if (TIMEOUT_CYCLES < 2 || FILTER_DEPTH < 1) begin : g_bad_params
    $error("pwm_capture: TIMEOUT_CYCLES must be >= 2 and FILTER_DEPTH >= 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HIGH  = 2'd1,
    ST_LOW   = 2'd2,
    ST_STUCK = 2'd3
  } state_e;

  state_e       state_q, state_d;
  logic         sync1_q, sync1_d;
  logic         sync2_q, sync2_d;
  logic         lvl;
  logic         lvl_dly_q, lvl_dly_d;
  logic         rise, fall;
  logic [W-1:0] hcnt_q, hcnt_d;
  logic [W-1:0] lcnt_q, lcnt_d;
  logic [W-1:0] duty_q, duty_d;
  logic [W-1:0] period_q, period_d;
  logic         sample_valid_q, sample_valid_d;
  logic         stuck_high_q, stuck_high_d;
  logic         stuck_low_q, stuck_low_d;
  logic         locked_q, locked_d;
  // Set once a measurement has started from a rise; a sample needs a high
  // phase that was observed from its rising edge.
  logic         armed_q, armed_d;

  // Counters stop at the timeout value instead of wrapping
  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

`ifdef PWM_CAPTURE_FILTER_EN
  localparam int unsigned FW = (FILTER_DEPTH > 1) ? $clog2(FILTER_DEPTH) : 1;
  localparam logic [FW-1:0] FCNT_LAST = FW'(FILTER_DEPTH - 1);

  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;

  // Glitch filter: follow the synchronized line only after it has differed
  // from the filtered value for FILTER_DEPTH consecutive cycles.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (sync2_q != filt_q) begin
      if (fcnt_q == FCNT_LAST) begin
        filt_d = sync2_q;
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_q <= 1'b0;
      fcnt_q <= '0;
    end else begin
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = sync2_q;
`endif

  assign rise = lvl & ~lvl_dly_q;
  assign fall = ~lvl & lvl_dly_q;

  // Next-state and measurement logic
  always_comb begin
    sync1_d        = bus.pwm_in;
    sync2_d        = sync1_q;
    lvl_dly_d      = lvl;
    state_d        = state_q;
    hcnt_d         = hcnt_q;
    lcnt_d         = lcnt_q;
    duty_d         = duty_q;
    period_d       = period_q;
    sample_valid_d = 1'b0;
    stuck_high_d   = stuck_high_q;
    stuck_low_d    = stuck_low_q;
    locked_d       = locked_q;
    armed_d        = armed_q;

    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d = ST_HIGH;
          hcnt_d  = CNT_ONE;
          lcnt_d  = '0;
          armed_d = 1'b1;
        end else if (!lvl) begin
          lcnt_d = sat_inc(lcnt_q);
          if (lcnt_q == CNT_LAST) begin
            stuck_low_d = 1'b1;
            locked_d    = 1'b0;
            armed_d     = 1'b0;
            state_d     = ST_STUCK;
          end
        end
      end

      ST_HIGH: begin
        if (fall) begin
          state_d = ST_LOW;
          lcnt_d  = CNT_ONE;
        end else if (lvl) begin
          hcnt_d = sat_inc(hcnt_q);
          if (hcnt_q == CNT_LAST) begin
            stuck_high_d = 1'b1;
            locked_d     = 1'b0;
            armed_d      = 1'b0;
            state_d      = ST_STUCK;
          end
        end
      end

      ST_LOW: begin
        if (rise) begin
          // A rise closes the period only if its high phase was fully seen
          if (armed_q) begin
            duty_d         = hcnt_q;
            period_d       = W'(hcnt_q + lcnt_q);
            sample_valid_d = 1'b1;
            locked_d       = 1'b1;
          end
          armed_d = 1'b1;
          state_d = ST_HIGH;
          hcnt_d  = CNT_ONE;
          lcnt_d  = '0;
        end else if (!lvl) begin
          lcnt_d = sat_inc(lcnt_q);
          if (lcnt_q == CNT_LAST) begin
            stuck_low_d = 1'b1;
            locked_d    = 1'b0;
            armed_d     = 1'b0;
            state_d     = ST_STUCK;
          end
        end
      end

      ST_STUCK: begin
        // Any edge ends the stuck condition; a fall restarts mid-period,
        // so the following rise must not produce a sample.
        if (rise) begin
          stuck_high_d = 1'b0;
          stuck_low_d  = 1'b0;
          state_d      = ST_HIGH;
          hcnt_d       = CNT_ONE;
          lcnt_d       = '0;
          armed_d      = 1'b1;
        end else if (fall) begin
          stuck_high_d = 1'b0;
          stuck_low_d  = 1'b0;
          state_d      = ST_LOW;
          lcnt_d       = CNT_ONE;
          armed_d      = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q        <= 1'b0;
      sync2_q        <= 1'b0;
      lvl_dly_q      <= 1'b0;
      state_q        <= ST_IDLE;
      hcnt_q         <= '0;
      lcnt_q         <= '0;
      duty_q         <= '0;
      period_q       <= '0;
      sample_valid_q <= 1'b0;
      stuck_high_q   <= 1'b0;
      stuck_low_q    <= 1'b0;
      locked_q       <= 1'b0;
      armed_q        <= 1'b0;
    end else begin
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      lvl_dly_q      <= lvl_dly_d;
      state_q        <= state_d;
      hcnt_q         <= hcnt_d;
      lcnt_q         <= lcnt_d;
      duty_q         <= duty_d;
      period_q       <= period_d;
      sample_valid_q <= sample_valid_d;
      stuck_high_q   <= stuck_high_d;
      stuck_low_q    <= stuck_low_d;
      locked_q       <= locked_d;
      armed_q        <= armed_d;
    end
  end

  assign bus.duty         = duty_q;
  assign bus.period       = period_q;
  assign bus.sample_valid = sample_valid_q;
  assign bus.stuck_high   = stuck_high_q;
  assign bus.stuck_low    = stuck_low_q;
  assign bus.locked       = locked_q;

endmodule
